// File: rtl/timer_pkg.sv
// Shared definitions for the button sequencer: run-state encoding, default timing
// constants for 100 MHz hardware and shortened values for simulation.
package timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DEBOUNCE_CYCLES = 32'd1_000_000;
    localparam int DEF_REPEAT_DELAY    = 32'd50_000_000;
    localparam int DEF_REPEAT_RATE     = 32'd10_000_000;

    localparam int SIM_DEBOUNCE_CYCLES = 32'd4;
    localparam int SIM_REPEAT_DELAY    = 32'd10;
    localparam int SIM_REPEAT_RATE     = 32'd3;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button input path: two-flop synchroniser, stable-count debouncer and a
// registered press pulse raised together with the debounced level.
module btn_debounce
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_r;
    logic          sync2_r;
    logic          level_r;
    logic          press_r;
    logic [CW-1:0] cnt_r;

    // Synchronise, count consecutive disagreeing samples, flip the level and flag a rise.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_r <= 1'b0;
            sync2_r <= 1'b0;
            level_r <= 1'b0;
            press_r <= 1'b0;
            cnt_r   <= '0;
        end else begin
            sync1_r <= btn_raw;
            sync2_r <= sync1_r;
            press_r <= 1'b0;
            if (sync2_r == level_r) begin
                cnt_r <= '0;
            end else if (cnt_r >= CNT_LAST) begin
                level_r <= sync2_r;
                press_r <= sync2_r;
                cnt_r   <= '0;
            end else begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    assign level = level_r;
    assign press = press_r;

endmodule

// File: rtl/timer_ctrl.sv
// Button sequencer for the countdown timer: debounced presses become one-cycle
// commands, set buttons auto-repeat while held in IDLE, and IDLE/RUN/DONE is tracked here.
module timer_ctrl
    import timer_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
    parameter int REPEAT_RATE     = DEF_REPEAT_RATE
) (
    input  logic clk_100MHz,
    input  logic reset,
    input  logic btn_start_stop,
    input  logic btn_set_min,
    input  logic btn_set_sec,
    input  logic timer_done,
    input  logic timer_zero,
    output logic start_stop_pulse,
    output logic set_min_pulse,
    output logic set_sec_pulse,
    output logic running,
    output logic alarm_clear
);

    localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);
    localparam logic [RW-1:0] DELAY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] RATE_LAST  = RW'(REPEAT_RATE - 1);
    localparam logic [RW-1:0] RCNT_MAX   = {RW{1'b1}};

    logic start_level_unused_s;
    logic start_press_s;
    logic min_level_s;
    logic min_press_s;
    logic sec_level_s;
    logic sec_press_s;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_start (
        .clk(clk_100MHz), .reset(reset), .btn_raw(btn_start_stop),
        .level(start_level_unused_s), .press(start_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_min (
        .clk(clk_100MHz), .reset(reset), .btn_raw(btn_set_min),
        .level(min_level_s), .press(min_press_s)
    );
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_sec (
        .clk(clk_100MHz), .reset(reset), .btn_raw(btn_set_sec),
        .level(sec_level_s), .press(sec_press_s)
    );

    state_t        state_r;
    logic          start_stop_r;
    logic          set_min_r;
    logic          set_sec_r;
    logic          running_r;
    logic          alarm_clear_r;
    logic [RW-1:0] min_cnt_r;
    logic [RW-1:0] sec_cnt_r;
    logic          min_fast_r;
    logic          sec_fast_r;

    logic idle_s;
    logic go_run_s;
    logic sec_owner_s;
    logic min_fire_s;
    logic sec_fire_s;

    // set_min owns auto-repeat whenever it is held; set_sec only repeats on its own.
    assign idle_s      = (state_r == ST_IDLE);
    assign go_run_s    = start_press_s & ~timer_zero;
    assign sec_owner_s = sec_level_s & ~min_level_s;
    assign min_fire_s  = idle_s & min_level_s & ~min_press_s &
                         (min_cnt_r == (min_fast_r ? RATE_LAST : DELAY_LAST));
    assign sec_fire_s  = idle_s & sec_owner_s & ~sec_press_s &
                         (sec_cnt_r == (sec_fast_r ? RATE_LAST : DELAY_LAST));

    // Run-state FSM with prioritised command pulses and hold-to-repeat counters.
    always_ff @(posedge clk_100MHz) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            start_stop_r  <= 1'b0;
            set_min_r     <= 1'b0;
            set_sec_r     <= 1'b0;
            running_r     <= 1'b0;
            alarm_clear_r <= 1'b0;
            min_cnt_r     <= '0;
            sec_cnt_r     <= '0;
            min_fast_r    <= 1'b0;
            sec_fast_r    <= 1'b0;
        end else begin
            start_stop_r  <= 1'b0;
            set_min_r     <= 1'b0;
            set_sec_r     <= 1'b0;
            alarm_clear_r <= 1'b0;
            min_cnt_r     <= '0;
            sec_cnt_r     <= '0;
            min_fast_r    <= 1'b0;
            sec_fast_r    <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    running_r <= 1'b0;
                    // A fresh press or a fire restarts the count; release or leaving IDLE clears it.
                    if (!go_run_s) begin
                        if (min_fire_s) begin
                            min_fast_r <= 1'b1;
                        end else if (min_level_s && !min_press_s) begin
                            min_fast_r <= min_fast_r;
                            min_cnt_r  <= (min_cnt_r == RCNT_MAX) ? min_cnt_r : min_cnt_r + RW'(1);
                        end
                        if (sec_fire_s) begin
                            sec_fast_r <= 1'b1;
                        end else if (sec_owner_s && !sec_press_s) begin
                            sec_fast_r <= sec_fast_r;
                            sec_cnt_r  <= (sec_cnt_r == RCNT_MAX) ? sec_cnt_r : sec_cnt_r + RW'(1);
                        end
                    end
                    if (start_press_s) begin
                        if (go_run_s) begin
                            start_stop_r <= 1'b1;
                            running_r    <= 1'b1;
                            state_r      <= ST_RUN;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end else if (min_press_s || min_fire_s) begin
                        set_min_r <= 1'b1;
                    end else if (sec_press_s || sec_fire_s) begin
                        set_sec_r <= 1'b1;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    if (timer_done) begin
                        running_r <= 1'b0;
                        state_r   <= ST_DONE;
                    end else if (start_press_s) begin
                        start_stop_r <= 1'b1;
                        running_r    <= 1'b0;
                        state_r      <= ST_IDLE;
                    end else begin
                        running_r <= 1'b1;
                    end
                end
                ST_DONE: begin
                    running_r <= 1'b0;
                    if (start_press_s || min_press_s || sec_press_s) begin
                        alarm_clear_r <= 1'b1;
                        state_r       <= ST_IDLE;
                    end else if (!timer_done) begin
                        state_r <= ST_IDLE;
                    end else begin
                        state_r <= ST_DONE;
                    end
                end
                default: begin
                    running_r <= 1'b0;
                    state_r   <= ST_IDLE;
                end
            endcase
        end
    end

    assign start_stop_pulse = start_stop_r;
    assign set_min_pulse    = set_min_r;
    assign set_sec_pulse    = set_sec_r;
    assign running          = running_r;
    assign alarm_clear      = alarm_clear_r;

endmodule

// File: tb/tb_timer_ctrl.sv
// Directed bench for timer_ctrl at simulation scale (debounce 4, repeat delay 10, rate 3).
module tb_timer_ctrl;
    import timer_pkg::*;

    logic clk_100MHz = 1'b0;
    logic reset;
    logic btn_start_stop;
    logic btn_set_min;
    logic btn_set_sec;
    logic timer_done;
    logic timer_zero;
    logic start_stop_pulse;
    logic set_min_pulse;
    logic set_sec_pulse;
    logic running;
    logic alarm_clear;

    int checks = 0;
    int errors = 0;
    logic expv;

    always #5 clk_100MHz = ~clk_100MHz;

    timer_ctrl #(
        .DEBOUNCE_CYCLES(SIM_DEBOUNCE_CYCLES),
        .REPEAT_DELAY(SIM_REPEAT_DELAY),
        .REPEAT_RATE(SIM_REPEAT_RATE)
    ) dut (
        .clk_100MHz(clk_100MHz),
        .reset(reset),
        .btn_start_stop(btn_start_stop),
        .btn_set_min(btn_set_min),
        .btn_set_sec(btn_set_sec),
        .timer_done(timer_done),
        .timer_zero(timer_zero),
        .start_stop_pulse(start_stop_pulse),
        .set_min_pulse(set_min_pulse),
        .set_sec_pulse(set_sec_pulse),
        .running(running),
        .alarm_clear(alarm_clear)
    );

    task automatic tick();
        @(posedge clk_100MHz);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] expd);
        checks++;
        assert (obs === expd) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expd);
        end
    endtask

    initial begin
        reset = 1'b1;
        btn_start_stop = 1'b0;
        btn_set_min = 1'b0;
        btn_set_sec = 1'b0;
        timer_done = 1'b0;
        timer_zero = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", {3'b000, start_stop_pulse, set_min_pulse, set_sec_pulse, running, alarm_clear}, 8'h00);
        reset = 1'b0;
        repeat (2) tick();
        chk("post_reset_outputs", {3'b000, start_stop_pulse, set_min_pulse, set_sec_pulse, running, alarm_clear}, 8'h00);

        // 1: set_sec held -> pulses at 7, 17, 20, ... 38
        btn_set_sec = 1'b1;
        for (int c = 1; c <= 39; c++) begin
            tick();
            expv = (c == 7) || (c >= 17 && ((c - 17) % 3) == 0);
            chk($sformatf("t1_sec_c%0d", c), {7'd0, set_sec_pulse}, {7'd0, expv});
            chk("t1_min_quiet", {7'd0, set_min_pulse}, 8'h00);
        end
        btn_set_sec = 1'b0;
        repeat (8) tick();
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("t1_after_release", {7'd0, set_sec_pulse}, 8'h00);
        end

        // 2: bouncing set_min -> exactly one pulse 7 cycles after the final edge
        btn_set_min = 1'b1; tick();
        btn_set_min = 1'b0; tick();
        btn_set_min = 1'b1; tick();
        btn_set_min = 1'b0; tick();
        btn_set_min = 1'b1;
        for (int c = 1; c <= 12; c++) begin
            tick();
            chk($sformatf("t2_min_c%0d", c), {7'd0, set_min_pulse}, {7'd0, c == 7});
        end
        btn_set_min = 1'b0;
        repeat (20) tick();

        // 3: start in IDLE with a nonzero count, then set presses ignored in RUN
        btn_start_stop = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("t3_start_c%0d", c), {7'd0, start_stop_pulse}, {7'd0, c == 7});
            chk($sformatf("t3_run_c%0d", c), {7'd0, running}, {7'd0, c >= 7});
        end
        btn_start_stop = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("t3_release_quiet", {7'd0, start_stop_pulse}, 8'h00);
        end
        btn_set_min = 1'b1;
        for (int c = 0; c < 14; c++) begin
            tick();
            chk("t3_min_in_run", {7'd0, set_min_pulse}, 8'h00);
            chk("t3_still_running", {7'd0, running}, 8'h01);
        end
        btn_set_min = 1'b0;
        repeat (12) tick();

        // 4: timer_done beats a simultaneous start press; next press acknowledges DONE
        btn_start_stop = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 6) timer_done = 1'b1;
            chk("t4_no_start_pulse", {7'd0, start_stop_pulse}, 8'h00);
            chk($sformatf("t4_run_c%0d", c), {7'd0, running}, {7'd0, c < 7});
        end
        btn_start_stop = 1'b0;
        for (int c = 0; c < 12; c++) begin
            tick();
            chk("t4_done_quiet", {6'd0, alarm_clear, start_stop_pulse}, 8'h00);
        end
        btn_start_stop = 1'b1;
        for (int c = 1; c <= 8; c++) begin
            tick();
            chk($sformatf("t4_alarm_c%0d", c), {7'd0, alarm_clear}, {7'd0, c == 7});
            chk("t4_alarm_no_start", {7'd0, start_stop_pulse}, 8'h00);
        end
        btn_start_stop = 1'b0;
        timer_done = 1'b0;
        repeat (12) tick();

        // 5: start with an all-zero count is ignored
        timer_zero = 1'b1;
        btn_start_stop = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            tick();
            chk("t5_zero_ignored", {6'd0, start_stop_pulse, running}, 8'h00);
        end
        btn_start_stop = 1'b0;
        repeat (12) tick();
        timer_zero = 1'b0;

        // 6: reset mid-repeat clears everything; held button re-presses 7 cycles later
        btn_set_min = 1'b1;
        for (int c = 1; c <= 19; c++) begin
            tick();
            chk($sformatf("t6_pre_c%0d", c), {7'd0, set_min_pulse}, {7'd0, (c == 7) || (c == 17)});
        end
        reset = 1'b1;
        tick();
        chk("t6_reset_outputs_a", {3'b000, start_stop_pulse, set_min_pulse, set_sec_pulse, running, alarm_clear}, 8'h00);
        tick();
        chk("t6_reset_outputs_b", {3'b000, start_stop_pulse, set_min_pulse, set_sec_pulse, running, alarm_clear}, 8'h00);
        reset = 1'b0;
        for (int c = 1; c <= 9; c++) begin
            tick();
            chk($sformatf("t6_post_c%0d", c), {7'd0, set_min_pulse}, {7'd0, c == 7});
            chk("t6_post_others", {5'd0, start_stop_pulse, set_sec_pulse, alarm_clear}, 8'h00);
        end
        btn_set_min = 1'b0;
        repeat (12) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
